alu_result_queue: RTL
=====================

// Module: alu_result_queue
// PURPOSE
//  Downstream stage of the 32-bit ALU. Captures each ALU result and its Cout/Negative/Zero/Overflow
//  outputs into a DEPTH-entry FIFO with valid/ready handshakes on both sides.
//  Maintains the architectural NZCV flag register and a sticky overflow bit.
//  Feeds the registered C flag back to the ALU Cin so chained (add-with-carry) operations work.
// PARAMETERS
//  DATA_W  32  result width; must match ALU Y width
//  DEPTH   4   FIFO entries; power of two, >= 2
// PORTS
//  clk           in   1       single clock, all state updates on rising edge
//  rst           in   1       synchronous reset, active-high
//  in_valid      in   1       ALU result on in_* is valid this cycle
//  in_ready      out  1       queue can accept a result this cycle
//  in_y          in   DATA_W  ALU Y
//  in_cout       in   1       ALU Cout
//  in_neg        in   1       ALU Negative
//  in_zero       in   1       ALU Zero
//  in_ovf        in   1       ALU Overflow
//  in_upd_flags  in   1       1: this op writes NZCV; 0: flags unchanged (logic ops with S=0)
//  out_valid     out  1       head entry present
//  out_ready     in   1       consumer takes head entry this cycle
//  out_y         out  DATA_W  head entry result
//  out_flags     out  4       {N,Z,C,V} as they stood after the head entry's op
//  flags         out  4       current architectural {N,Z,C,V}
//  carry_fb      out  1       = flags[1] (C); drives ALU Cin
//  sticky_ovf    out  1       set on any accepted flag-updating op with in_ovf=1
//  clr_sticky    in   1       clear sticky_ovf
//  count         out  log2(DEPTH)+1  occupied entries, 0..DEPTH
// BEHAVIOUR
//  Clock and reset: one clock (clk); rst is synchronous, active-high.
//  Reset (rst=1 at edge): wr_ptr=rd_ptr=0, count=0, flags=4'b0000, sticky_ovf=0.
//   - While rst=1: in_ready=0, out_valid=0, out_y=0, out_flags=0.
//   - Reset mid-operation discards all entries; nothing is preserved.
//  Handshake:
//   - push = in_valid & in_ready.
//   - pop = out_valid & out_ready.
//   - in_ready = !rst & (count != DEPTH); combinational from count only, never from out_ready.
//   - in_* may change freely when in_valid=0.
//   - Producer holds in_* stable while in_valid=1 & in_ready=0.
//  Push:
//   - Writes entry[wr_ptr] = {in_y, nf}.
//   - nf = in_upd_flags ? {in_neg, in_zero, in_cout, in_ovf} : flags.
//   - flags <= nf at the same edge.
//   - wr_ptr increments modulo DEPTH (natural wrap).
//  Pop: rd_ptr increments modulo DEPTH.
//  Count: push&!pop +1; pop&!push -1; push&pop unchanged (legal whenever 0<count<DEPTH).
//  Full (count=DEPTH): in_ready=0, so a simultaneous pop does not admit a push that cycle.
//   - in_ready rises the cycle after the pop.
//  Empty (count=0): no bypass; out_valid=0, out_y=0, out_flags=0.
//  Latency: entry pushed at edge t is visible on out_* from t+1 (first-word-fall-through).
//  Flags/carry:
//   - flags and carry_fb update at the push edge.
//   - The next ALU op in the following cycle sees the new carry.
//  Sticky overflow:
//   - Set at a push with in_upd_flags&in_ovf.
//   - Cleared by clr_sticky.
//   - Set wins if both occur in the same cycle.
//  Output stability:
//   - out_y and out_flags are driven from storage and change only on pop or on a push into an empty queue.
//   - out_valid never deasserts without a pop, except by rst.
// TESTING
//  T1 reset: rst=1 for 2 cycles with in_valid=1
//     -> in_ready=0, out_valid=0, flags=0, count=0; first push accepted the cycle after rst falls.
//  T2 flags: push Y=0, zero=1, upd=1, then Y=5, upd=0
//     -> out_flags 4'b0100 then 4'b0100; flags=4'b0100.
//  T3 carry chain: push cout=1, upd=1 -> carry_fb=1 next cycle; push cout=0, upd=1 -> carry_fb=0.
//  T4 full/wrap: out_ready=0, push 4 entries (1..4)
//     -> count=4, in_ready=0; then pop+push 10 times -> FIFO order exact across pointer wrap.
//  T5 simultaneous: count=2, push&pop same cycle -> count stays 2; full + pop -> no push accepted that cycle.
//  T6 sticky: push ovf=1, upd=1 with clr_sticky=1 -> sticky_ovf=1; next cycle clr_sticky=1 -> 0;
//     ovf=1, upd=0 -> stays 0.

Source files
------------

// File: rtl/alu_result_queue.sv
// ALU result queue: FIFO of ALU results tagged with post-op NZCV,
// plus the architectural flag register, carry feedback and sticky overflow.
module alu_result_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_y,
  input  logic                     in_cout,
  input  logic                     in_neg,
  input  logic                     in_zero,
  input  logic                     in_ovf,
  input  logic                     in_upd_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_y,
  output logic [3:0]               out_flags,
  output logic [3:0]               flags,
  output logic                     carry_fb,
  output logic                     sticky_ovf,
  input  logic                     clr_sticky,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_y [DEPTH];
  logic [3:0]        r_f [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [CW-1:0]     r_count;
  logic [3:0]        r_flags;
  logic              r_sticky;

  logic              w_full;
  logic              w_nonempty;
  logic              w_push;
  logic              w_pop;
  logic [3:0]        w_nf;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_nonempty = (r_count != '0);

  assign in_ready  = !rst && !w_full;
  assign out_valid = !rst && w_nonempty;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Ops that do not set flags carry the current NZCV forward
  assign w_nf = in_upd_flags ? {in_neg, in_zero, in_cout, in_ovf}
                             : r_flags;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_y[r_wr] <= in_y;
      r_f[r_wr] <= w_nf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 4'b0000;
    end else if (w_push) begin
      r_flags <= w_nf;
    end
  end

  // A set in the same cycle as a clear takes priority
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 1'b0;
    end else if (w_push && in_upd_flags && in_ovf) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end

  assign out_y      = out_valid ? r_y[r_rd] : '0;
  assign out_flags  = out_valid ? r_f[r_rd] : 4'b0000;
  assign flags      = r_flags;
  assign carry_fb   = r_flags[1];
  assign sticky_ovf = r_sticky;
  assign count      = r_count;

endmodule
